// File: rtl/i2s_pkg.sv
// Shared constants for the I2S transmit block: counter width, clock bit
// positions within the free-running counter, and frame/slot decode points.
package i2s_pkg;

    localparam int unsigned SLOT_BITS = 32;
    localparam int unsigned SLOT_W    = $clog2(SLOT_BITS);
    localparam int unsigned CNT_W     = 10;

    // Bit positions of the generated clocks inside the free-running counter
    localparam int unsigned MCLK_B    = 1;
    localparam int unsigned SCLK_B    = 3;
    localparam int unsigned LRCLK_B   = 9;

    // Low counter nibble at which SCLK falls and SDin may change
    localparam logic [3:0]       SDIN_UPD   = 4'h0;
    // Counter value on which the next stereo pair is loaded
    localparam logic [CNT_W-1:0] FRM_LD_CNT = 10'h3FF;

endpackage

// File: rtl/i2s_clk_gen.sv
// Clock generator for the codec link: 10-bit free-running counter, registered
// MCLK/SCLK/LRCLK, and decode strobes used by the serializer.
module i2s_clk_gen
    import i2s_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    output logic              mclk,
    output logic              sclk,
    output logic              lrclk,
    output logic              sclk_fall,  // the coming edge makes SCLK fall
    output logic              frm_end,    // counter currently at the frame load value
    output logic [SLOT_W-1:0] slot        // slot index of the bit period that starts next
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next counter value; wraps 1023 -> 0 naturally
    always_comb begin
        cnt_d     = cnt_q + 1'b1;
        sclk_fall = (cnt_d[SCLK_B:0] == SDIN_UPD);
        slot      = cnt_d[LRCLK_B-1:SCLK_B+1];
    end

    // Counter and clock registers; clocks track the counter bits exactly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            mclk    <= 1'b0;
            sclk    <= 1'b0;
            lrclk   <= 1'b0;
            frm_end <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            mclk    <= cnt_d[MCLK_B];
            sclk    <= cnt_d[SCLK_B];
            lrclk   <= cnt_d[LRCLK_B];
            frm_end <= (cnt_d == FRM_LD_CNT);
        end
    end

endmodule

// File: rtl/i2s_sample_tx.sv
// I2S transmit side for the CS4272 codec: accepts one stereo pair per frame via
// valid/ready, serializes it MSB first with the I2S one-bit delay, and repeats
// the previous pair when no fresh sample arrived in time.
// Optional feature: define I2S_TX_UNDERRUN_CNT_EN to add the underrun_cnt port.
module i2s_sample_tx
    import i2s_pkg::*;
#(
    parameter int unsigned DATA_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] lft_in,
    input  logic [DATA_W-1:0] rht_in,
    input  logic              in_vld,
    output logic              in_rdy,
    output logic              frm_ld,
    output logic              MCLK,
    output logic              SCLK,
    output logic              LRCLK,
    output logic              SDin
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    output logic [15:0]       underrun_cnt
`endif
);

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(DATA_W);

    logic              sclk_fall;
    logic              frm_end;
    logic [SLOT_W-1:0] slot;

    logic                hold_full_q;
    logic                hold_full_d;
    logic                in_rdy_q;
    logic [DATA_W-1:0]   hold_lft_q;
    logic [DATA_W-1:0]   hold_rht_q;
    logic [DATA_W-1:0]   last_lft_q;
    logic [DATA_W-1:0]   last_rht_q;
    logic [2*DATA_W-1:0] shift_q;
    logic                sdin_q;
    logic                xfer;

    i2s_clk_gen u_clk_gen (
        .clk       (clk),
        .rst       (rst),
        .mclk      (MCLK),
        .sclk      (SCLK),
        .lrclk     (LRCLK),
        .sclk_fall (sclk_fall),
        .frm_end   (frm_end),
        .slot      (slot)
    );

    assign xfer   = in_vld & in_rdy_q;
    assign in_rdy = in_rdy_q;
    assign frm_ld = frm_end;
    assign SDin   = sdin_q;

    // Holding register occupancy: emptied by a frame load, filled by a transfer
    always_comb begin
        hold_full_d = hold_full_q;
        if (frm_end && hold_full_q) begin
            hold_full_d = 1'b0;
        end
        if (xfer) begin
            hold_full_d = 1'b1;
        end
    end

    // Holding register and registered ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_full_q <= 1'b0;
            in_rdy_q    <= 1'b1;
            hold_lft_q  <= '0;
            hold_rht_q  <= '0;
        end else begin
            hold_full_q <= hold_full_d;
            in_rdy_q    <= ~hold_full_d;
            if (xfer) begin
                hold_lft_q <= lft_in;
                hold_rht_q <= rht_in;
            end
        end
    end

    // Frame load and serializer; the right half continues shifting the same
    // register, so after DATA_W shifts the right sample sits at the MSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q    <= '0;
            last_lft_q <= '0;
            last_rht_q <= '0;
            sdin_q     <= 1'b0;
        end else if (frm_end) begin
            if (hold_full_q) begin
                shift_q    <= {hold_lft_q, hold_rht_q};
                last_lft_q <= hold_lft_q;
                last_rht_q <= hold_rht_q;
            end else begin
                shift_q <= {last_lft_q, last_rht_q};
            end
            sdin_q <= 1'b0;  // slot 0 of the left half
        end else if (sclk_fall) begin
            if ((slot != '0) && (slot <= LAST_SLOT)) begin
                sdin_q  <= shift_q[2*DATA_W-1];
                shift_q <= {shift_q[2*DATA_W-2:0], 1'b0};
            end else begin
                sdin_q <= 1'b0;
            end
        end
    end

`ifdef I2S_TX_UNDERRUN_CNT_EN
    // Saturating count of frames that went out without a fresh pair
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underrun_cnt <= '0;
        end else if (frm_end && !hold_full_q && (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_i2s_sample_tx.sv
// Directed bench for i2s_sample_tx: clock timing, async reset, handshake stalls,
// underrun repeat, capture at the frame boundary and a short random burst.
module tb_i2s_sample_tx;

    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] lft = '0;
    logic [DW-1:0] rht = '0;
    logic          vld = 1'b0;
    logic          in_rdy, frm_ld, MCLK, SCLK, LRCLK, SDin;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [15:0]   urun;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        bit            fmt_ok;
    } frame_t;

    frame_t frames[$];

    i2s_sample_tx #(.DATA_W(DW)) dut (
        .clk    (clk),
        .rst    (rst),
        .lft_in (lft),
        .rht_in (rht),
        .in_vld (vld),
        .in_rdy (in_rdy),
        .frm_ld (frm_ld),
        .MCLK   (MCLK),
        .SCLK   (SCLK),
        .LRCLK  (LRCLK),
        .SDin   (SDin)
`ifdef I2S_TX_UNDERRUN_CNT_EN
        ,
        .underrun_cnt (urun)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Frame deserializer: a frame starts the cycle after frm_ld (cnt==0)
    initial begin
        bit            act = 0;
        logic [9:0]    pos = '0;
        logic          prev = 1'b0;
        frame_t        cur;
        forever begin
            @(negedge clk);
            if (rst) begin
                act = 0;
            end else if (frm_ld) begin
                if (act) frames.push_back(cur);
                act        = 1;
                pos        = 10'h3FF;
                cur.l      = '0;
                cur.r      = '0;
                cur.fmt_ok = 1;
                prev       = SDin;
            end else if (act) begin
                int s;
                pos = pos + 10'd1;
                s   = int'(pos[8:4]);
                if (pos[3:0] != 4'h0 && SDin !== prev) cur.fmt_ok = 0;
                prev = SDin;
                if (pos[3:0] == 4'h8) begin
                    if (s >= 1 && s <= DW) begin
                        if (pos[9]) cur.r[DW-s] = SDin;
                        else        cur.l[DW-s] = SDin;
                    end else if (SDin !== 1'b0) begin
                        cur.fmt_ok = 0;
                    end
                end
            end
        end
    end

    task automatic push(input logic [DW-1:0] l, input logic [DW-1:0] r, output int waited);
        @(negedge clk);
        lft    = l;
        rht    = r;
        vld    = 1'b1;
        waited = 0;
        while (!in_rdy && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        chk("push_rdy", in_rdy, 1'b1);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        vld = 1'b0;
    endtask

    // Returns at negedge+1 of the frm_ld cycle that completes frame n
    task automatic wait_frames(input int n);
        int k = 0;
        while (frames.size() < n && k < 5000) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("frame_timeout", frames.size() >= n, 1'b1);
    endtask

    task automatic chk_frame(input int i, input logic [DW-1:0] l, input logic [DW-1:0] r);
        frame_t f;
        f.l = 'x;
        f.r = 'x;
        f.fmt_ok = 0;
        if (i < frames.size()) f = frames[i];
        chk($sformatf("frame%0d_lft", i), f.l, l);
        chk($sformatf("frame%0d_rht", i), f.r, r);
        chk($sformatf("frame%0d_fmt", i), f.fmt_ok, 1'b1);
    endtask

    initial begin
        int            w;
        int            k;
        logic [9:0]    c;
        logic [DW-1:0] rl[16];
        logic [DW-1:0] rr[16];

        // Reset state
        #23;
        chk("rst_mclk", MCLK, 1'b0);
        chk("rst_sclk", SCLK, 1'b0);
        chk("rst_lrclk", LRCLK, 1'b0);
        chk("rst_sdin", SDin, 1'b0);
        chk("rst_frm_ld", frm_ld, 1'b0);
        chk("rst_in_rdy", in_rdy, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // Clock generation: after n edges the counter is n mod 1024
        for (int n = 1; n <= 1100; n++) begin
            @(posedge clk);
            @(negedge clk);
            c = 10'(n);
            chk("mclk", MCLK, c[1]);
            chk("sclk", SCLK, c[3]);
            chk("lrclk", LRCLK, c[9]);
            chk("frm_ld_pos", frm_ld, c == 10'h3FF);
            chk("sdin_idle", SDin, 1'b0);
        end

        // Mid-frame async reset with the holding register full
        push(24'h111111, 24'h222222, w);
        idle();
        chk("hold_full_rdy", in_rdy, 1'b0);
        k = 0;
        while (!LRCLK && k < 1100) begin
            @(negedge clk);
            k++;
        end
        chk("lrclk_rise", LRCLK, 1'b1);
        repeat (88) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_mclk", MCLK, 1'b0);
        chk("arst_sclk", SCLK, 1'b0);
        chk("arst_lrclk", LRCLK, 1'b0);
        chk("arst_sdin", SDin, 1'b0);
        chk("arst_frm_ld", frm_ld, 1'b0);
        chk("arst_in_rdy", in_rdy, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        frames.delete();

        // Pattern, back-to-back stall, then underrun repeat of the last pair
        push(24'hA50F3C, 24'h5AF0C3, w);
        chk("a_nostall", w, 0);
        #1;
        chk("a_rdy_low", in_rdy, 1'b0);
        push(24'h13579B, 24'hECA864, w);
        chk("b_stall", w > 0, 1'b1);
        push(24'h7FFFFF, 24'h800000, w);
        chk("c_stall", w > 0, 1'b1);
        idle();
        wait_frames(3);
        chk_frame(0, 24'hA50F3C, 24'h5AF0C3);
        chk_frame(1, 24'h13579B, 24'hECA864);
        chk_frame(2, 24'h7FFFFF, 24'h800000);
`ifdef I2S_TX_UNDERRUN_CNT_EN
        chk("urun_before", urun, 16'd0);
        @(negedge clk);
        #1;
        chk("urun_one", urun, 16'd1);
`endif
        wait_frames(4);
        chk_frame(3, 24'h7FFFFF, 24'h800000);

        // Reset with no push: zeros frame, one underrun
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        frames.delete();
        wait_frames(1);
        chk_frame(0, 24'h000000, 24'h000000);
`ifdef I2S_TX_UNDERRUN_CNT_EN
        chk("urun_after_rst", urun, 16'd1);
`endif

        // Valid pulse exactly at the frame-load cycle with holding empty
        chk("edge_frm_ld", frm_ld, 1'b1);
        chk("edge_in_rdy", in_rdy, 1'b1);
        lft = 24'h123456;
        rht = 24'hFEDCBA;
        vld = 1'b1;
        @(posedge clk);
        #1;
        vld = 1'b0;
        chk("edge_captured", in_rdy, 1'b0);
        wait_frames(3);
        chk_frame(1, 24'h000000, 24'h000000);
        chk_frame(2, 24'h123456, 24'hFEDCBA);
`ifdef I2S_TX_UNDERRUN_CNT_EN
        chk("urun_edge", urun, 16'd2);
`endif

        // Random burst, pushed as fast as the handshake allows
        for (int i = 0; i < 16; i++) begin
            rl[i] = DW'($urandom);
            rr[i] = DW'($urandom);
            push(rl[i], rr[i], w);
        end
        idle();
        wait_frames(20);
        chk_frame(3, 24'h123456, 24'hFEDCBA);
        for (int i = 0; i < 16; i++) begin
            chk_frame(4 + i, rl[i], rr[i]);
        end
`ifdef I2S_TX_UNDERRUN_CNT_EN
        chk("urun_random", urun, 16'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
